btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_pkg.sv | 16 +
 rtl/btn_conditioner_if.sv | 13 +
 rtl/btn_conditioner_sync_2ff.sv | 23 ++
 rtl/btn_conditioner.sv | 140 ++++++++++++++
 tb/tb_btn_conditioner.sv | 119 +++++++++++
 5 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// default timing constants for a 100 MHz system clock.
package btn_cond_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t IDLE    = 2'd0;
  localparam fsm_state_t PRESSED = 2'd1;
  localparam fsm_state_t REPEAT  = 2'd2;

  // 5 ms debounce, 500 ms to first repeat, 100 ms between repeats at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT     = 500000;
  localparam int unsigned REPEAT_DELAY_CYCLES_DEFAULT = 50000000;
  localparam int unsigned REPEAT_RATE_CYCLES_DEFAULT  = 10000000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button signal bundle: raw input level plus the conditioned level/pulse/held outputs.
interface btn_conditioner_if;

  logic btn_in;
  logic level;
  logic pulse;
  logic held;

  // master: the conditioner itself; slave: the board pin driver / event consumer
  modport master (input btn_in, output level, output pulse, output held);
  modport slave  (output btn_in, input level, input pulse, input held);

endinterface

// File: rtl/btn_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reusable for any width.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronize, debounce, single press pulse and optional
// auto-repeat (compiled in when BTN_AUTO_REPEAT_EN is defined).
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.master  btn
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_param_check
    $error("btn_conditioner: timing parameters must be >= 1");
  end

  logic            sync;
  logic [DB_W-1:0] db_cnt;
  logic            level_q;
  logic            level_nxt;
  logic            rise;
  logic            fall;
  logic            pulse_q;
  fsm_state_t      state;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn.btn_in),
    .q   (sync)
  );

  // Level flips on the cycle after the counter has seen DEBOUNCE_CYCLES
  // consecutive disagreeing samples; the FSM reacts to that same edge.
  always_comb begin
    level_nxt = level_q;
    if (sync != level_q && db_cnt == DB_W'(DEBOUNCE_CYCLES))
      level_nxt = ~level_q;
  end

  assign rise = ~level_q &  level_nxt;
  assign fall =  level_q & ~level_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
    end else begin
      level_q <= level_nxt;
      if (sync == level_q || db_cnt == DB_W'(DEBOUNCE_CYCLES))
        db_cnt <= '0;
      else
        db_cnt <= db_cnt + DB_W'(1);
    end
  end

`ifdef BTN_AUTO_REPEAT_EN

  localparam int unsigned DL_W = $clog2(REPEAT_DELAY_CYCLES + 1);
  localparam int unsigned RT_W = $clog2(REPEAT_RATE_CYCLES + 1);

  logic [DL_W-1:0] dly_cnt;
  logic [RT_W-1:0] rate_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pulse_q  <= 1'b0;
      dly_cnt  <= '0;
      rate_cnt <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (fall) begin
        state    <= IDLE;
        dly_cnt  <= '0;
        rate_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state   <= PRESSED;
              pulse_q <= 1'b1;
              dly_cnt <= '0;
            end
          end
          PRESSED: begin
            if (dly_cnt == DL_W'(REPEAT_DELAY_CYCLES - 1)) begin
              state    <= REPEAT;
              pulse_q  <= 1'b1;
              dly_cnt  <= '0;
              rate_cnt <= '0;
            end else begin
              dly_cnt <= dly_cnt + DL_W'(1);
            end
          end
          REPEAT: begin
            if (rate_cnt == RT_W'(REPEAT_RATE_CYCLES - 1)) begin
              pulse_q  <= 1'b1;
              rate_cnt <= '0;
            end else begin
              rate_cnt <= rate_cnt + RT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign btn.held = (state == REPEAT);

`else

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (fall) begin
        state <= IDLE;
      end else if (state == IDLE && rise) begin
        state   <= PRESSED;
        pulse_q <= 1'b1;
      end
    end
  end

  assign btn.held = 1'b0;

`endif

  assign btn.level = level_q;
  assign btn.pulse = pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing (4/20/8); expectations
// follow BTN_AUTO_REPEAT_EN when it is defined for the build.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  btn_conditioner_if bif ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_RATE_CYCLES  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
      end
  endtask

  // Drive inputs for the next rising edge, then sample just after it.
  task automatic step(input logic b, input logic r);
    bif.btn_in = b;
    rst        = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bif.btn_in = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    check("reset_level", bif.level, 1'b0);
    check("reset_pulse", bif.pulse, 1'b0);
    check("reset_held",  bif.held,  1'b0);
  endtask

  task automatic check_outs(input string scen, input logic el, input logic ep, input logic eh);
    check({scen, "_level"}, bif.level, el);
    check({scen, "_pulse"}, bif.pulse, ep);
    check({scen, "_held"},  bif.held,  eh);
  endtask

  initial begin
    logic b, el, ep, eh;
    bif.btn_in = 1'b0;

    // Clean press: 1 on edges 10..19 -> level 16..25, pulse at 16 only
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      b = (k >= 10 && k < 20);
      step(b, 1'b0);
      el = (k >= 16 && k < 26);
      ep = (k == 16);
      check_outs("clean", el, ep, 1'b0);
    end

    // Bounce: two-cycle glitches never reach the debounce threshold
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      b = (k >= 10 && k < 12) || (k >= 14 && k < 16) || (k >= 18 && k < 20);
      step(b, 1'b0);
      check_outs("bounce", 1'b0, 1'b0, 1'b0);
    end

    // Long hold: 1 on edges 10..59, release at 60
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      b = (k >= 10 && k < 60);
      step(b, 1'b0);
      el = (k >= 16 && k < 66);
`ifdef BTN_AUTO_REPEAT_EN
      ep = (k == 16 || k == 36 || k == 44 || k == 52 || k == 60);
      eh = (k >= 36 && k < 66);
`else
      ep = (k == 16);
      eh = 1'b0;
`endif
      check_outs("hold", el, ep, eh);
    end

    // Reset asserted on edges 40,41 while the button stays pressed
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      b = (k >= 10);
      step(b, (k == 40 || k == 41));
      el = (k >= 16 && k < 40) || (k >= 48);
`ifdef BTN_AUTO_REPEAT_EN
      ep = (k == 16 || k == 36 || k == 48 || k == 68 || k == 76);
      eh = (k >= 36 && k < 40) || (k >= 68);
`else
      ep = (k == 16 || k == 48);
      eh = 1'b0;
`endif
      check_outs("rst_hold", el, ep, eh);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
